// File: rtl/mcycle_sequencer.sv
// Multi-cycle mul/div unit with its own sequencer: Start in cycle T stalls via Busy for T..T+WIDTH, Done pulses at T+WIDTH+1.
// Optional MCYCLE_EARLY_TERM_EN lets multiplies finish once the remaining multiplier is zero.
module mcycle_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_op1;
  logic [WIDTH-1:0]   r_res1;
  logic [WIDTH-1:0]   r_res2;

  logic               w_accept;
  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_sub;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;
  logic               w_last;

  // Start is only honoured outside COMPUTE; the stall starts combinationally with it.
  assign w_accept = (r_state != S_COMPUTE) && Start;
  assign Busy     = w_accept || (r_state == S_COMPUTE);
  assign Done     = (r_state == S_DONE);
  assign Result1  = r_res1;
  assign Result2  = r_res2;

  assign w_sign_a = ~MCycleOp[0] & Operand1[WIDTH-1];
  assign w_sign_b = ~MCycleOp[0] & Operand2[WIDTH-1];
  assign w_mag_a  = w_sign_a ? -Operand1 : Operand1;
  assign w_mag_b  = w_sign_b ? -Operand2 : Operand2;

  assign w_acc_nxt = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
  assign w_prod    = r_neg_q ? -w_acc_nxt : w_acc_nxt;

  // Restoring step: the top bit of w_sub is the borrow, i.e. shifted remainder < divisor.
  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_sub     = w_rem_sh - {1'b0, r_dvs};
  assign w_ge      = ~w_sub[WIDTH];
  assign w_rem_nxt = w_ge ? w_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
  assign w_q_fix   = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_r_fix   = r_neg_r ? -w_rem_nxt : w_rem_nxt;

`ifdef MCYCLE_EARLY_TERM_EN
  assign w_last = (r_count == LAST) || (!r_is_div && (r_mplr[WIDTH-1:1] == '0));
`else
  assign w_last = (r_count == LAST);
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplr   <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_op1    <= '0;
      r_res1   <= '0;
      r_res2   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            r_state  <= S_COMPUTE;
            r_count  <= '0;
            r_is_div <= MCycleOp[1];
            r_neg_q  <= w_sign_a ^ w_sign_b;
            r_neg_r  <= w_sign_a;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplr   <= w_mag_b;
            r_quo    <= w_mag_a;
            r_rem    <= '0;
            r_dvs    <= w_mag_b;
            r_op1    <= Operand1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_COMPUTE: begin
          r_count <= r_count + 1'b1;
          r_acc   <= w_acc_nxt;
          r_mcand <= {r_mcand[2*WIDTH-2:0], 1'b0};
          r_mplr  <= {1'b0, r_mplr[WIDTH-1:1]};
          r_quo   <= w_quo_nxt;
          r_rem   <= w_rem_nxt;
          if (w_last) begin
            r_state <= S_DONE;
            if (!r_is_div) begin
              r_res1 <= w_prod[WIDTH-1:0];
              r_res2 <= w_prod[2*WIDTH-1:WIDTH];
            end else if (r_dvs == '0) begin
              // Divide-by-zero reports the raw dividend, not its sign-fixed magnitude.
              r_res1 <= '1;
              r_res2 <= r_op1;
            end else begin
              r_res1 <= w_q_fix;
              r_res2 <= w_r_fix;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_sequencer.sv
// Scoreboard bench for mcycle_sequencer: stimulus queues expected results and Done cycle, a monitor checks each Done.
module tb_mcycle_sequencer;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         Start;
  logic [1:0]   MCycleOp;
  logic [W-1:0] Operand1;
  logic [W-1:0] Operand2;
  logic [W-1:0] Result1;
  logic [W-1:0] Result2;
  logic         Busy;
  logic         Done;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    int           when;
    int           id;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  mcycle_sequencer #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Expected COMPUTE cycle count for an op.
  function automatic int lat(input logic [1:0] op, input logic [W-1:0] b);
    int n;
    n = W;
`ifdef MCYCLE_EARLY_TERM_EN
    if (!op[1]) begin
      logic [W-1:0] m;
      m = (!op[0] && b[W-1]) ? -b : b;
      n = 1;
      for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    end
`endif
    return n;
  endfunction

  // Monitor: every Done must match the oldest queued expectation, including its cycle.
  always @(negedge CLK) begin
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        check($sformatf("unexpected_done@%0d", cyc), {63'b0, Done}, 64'd0);
      end else begin
        e = sb.pop_front();
        check($sformatf("op%0d_result1", e.id), {32'b0, Result1}, {32'b0, e.r1});
        check($sformatf("op%0d_result2", e.id), {32'b0, Result2}, {32'b0, e.r2});
        check($sformatf("op%0d_done_cycle", e.id), 64'(cyc), 64'(e.when));
      end
    end
  end

  task automatic issue(input int id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] e1, input logic [W-1:0] e2, input bit push, output int t);
    exp_t x;
    @(posedge CLK); #1;
    MCycleOp = op; Operand1 = a; Operand2 = b; Start = 1'b1;
    t = cyc;
    if (push) begin
      x.r1 = e1; x.r2 = e2; x.when = t + lat(op, b) + 1; x.id = id;
      sb.push_back(x);
    end
    @(negedge CLK);
    check($sformatf("op%0d_busy_at_start", id), {63'b0, Busy}, 64'd1);
    @(posedge CLK); #1;
    Start = 1'b0;
    Operand1 = $urandom; Operand2 = $urandom; MCycleOp = 2'($urandom_range(0, 3));
  endtask

  task automatic drain(input int id);
    int i;
    i = 0;
    while (sb.size() > 0 && i < 200) begin
      @(negedge CLK);
      i++;
    end
    check($sformatf("op%0d_drained", id), 64'(sb.size()), 64'd0);
    sb.delete();
    repeat (3) @(negedge CLK);
  endtask

  task automatic run(input int id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] e1, input logic [W-1:0] e2);
    int t;
    issue(id, op, a, b, e1, e2, 1'b1, t);
    drain(id);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    exp_t x;
    RESET = 1'b1; Start = 1'b0; MCycleOp = 2'b00; Operand1 = '0; Operand2 = '0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("reset_busy", {63'b0, Busy}, 64'd0);
    check("reset_done", {63'b0, Done}, 64'd0);
    check("reset_result1", {32'b0, Result1}, 64'd0);
    check("reset_result2", {32'b0, Result2}, 64'd0);

    // Full-width unsigned multiply with Busy window checks.
    issue(1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1, t);
    while (cyc != t + 32) @(negedge CLK);
    check("op1_busy_T+32", {63'b0, Busy}, 64'd1);
    @(negedge CLK);
    check("op1_busy_T+33", {63'b0, Busy}, 64'd0);
    drain(1);

    run(2, 2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 32'hFFFFFFFF);
    run(3, 2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF);
    run(4, 2'b11, 32'd100,      32'd7,        32'd14,       32'd2);
    run(5, 2'b11, 32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234);
    run(6, 2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9);
    run(7, 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
    run(8, 2'b10, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001);
    run(9, 2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000);

    // Start re-pulsed mid-COMPUTE with other operands: must be ignored.
    issue(10, 2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1, t);
    repeat (4) @(posedge CLK);
    #1 Start = 1'b1; MCycleOp = 2'b01; Operand1 = 32'd9; Operand2 = 32'd9;
    @(negedge CLK);
    check("op10_busy_T+5", {63'b0, Busy}, 64'd1);
    @(posedge CLK); #1 Start = 1'b0;
    drain(10);

    // Back-to-back: Start held high, second op accepted in the DONE cycle.
    @(posedge CLK); #1;
    MCycleOp = 2'b11; Operand1 = 32'd100; Operand2 = 32'd7; Start = 1'b1;
    t = cyc;
    x.r1 = 32'd14; x.r2 = 32'd2; x.when = t + 33; x.id = 11;
    sb.push_back(x);
    x.r1 = 32'hFFFFFFFD; x.r2 = 32'hFFFFFFFF; x.when = t + 66; x.id = 12;
    sb.push_back(x);
    repeat (2) @(posedge CLK);
    #1 MCycleOp = 2'b10; Operand1 = 32'hFFFFFFF9; Operand2 = 32'd2;
    while (cyc != t + 33) @(negedge CLK);
    check("op11_busy_in_done", {63'b0, Busy}, 64'd1);
    @(posedge CLK); #1 Start = 1'b0;
    drain(12);

    // Reset mid-operation drops the op: no Done, outputs cleared.
    issue(13, 2'b11, 32'h00001234, 32'd7, 32'd0, 32'd0, 1'b0, t);
    repeat (9) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK); #1 RESET = 1'b0;
    @(negedge CLK);
    check("midreset_busy", {63'b0, Busy}, 64'd0);
    check("midreset_done", {63'b0, Done}, 64'd0);
    check("midreset_result1", {32'b0, Result1}, 64'd0);
    check("midreset_result2", {32'b0, Result2}, 64'd0);
    repeat (40) @(negedge CLK);

    // Small multiplier (early exit when enabled) and zero multiplier.
    run(14, 2'b01, 32'd5, 32'd3, 32'd15, 32'd0);
    run(15, 2'b01, 32'd9, 32'd0, 32'd0,  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
